// File: rtl/tmr32_pwm_seq_ctrl.sv
// Wishbone master that programs a 32-bit timer/PWM and steps its compare value
// through a local duty table, one entry per timeout interrupt.
module tmr32_pwm_seq_ctrl #(
    parameter logic [31:0] TMR_BASE = 32'h0000_0000,
    parameter int          DEPTH    = 16,
    parameter int          AW       = 4,
    parameter logic [3:0]  CLK_SRC  = 4'd0,
    parameter int          ACK_TO   = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          loop_i,
    input  logic [31:0]   period_i,
    input  logic [AW:0]   seq_len_i,
    input  logic          tbl_we_i,
    input  logic [AW-1:0] tbl_addr_i,
    input  logic [31:0]   tbl_wdata_i,
    output logic [31:0]   m_adr_o,
    output logic [31:0]   m_dat_o,
    input  logic [31:0]   m_dat_i,
    output logic [3:0]    m_sel_o,
    output logic          m_cyc_o,
    output logic          m_stb_o,
    output logic          m_we_o,
    input  logic          m_ack_i,
    input  logic          tmr_irq_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-1:0] step_o
);

    localparam logic [31:0] OFF_PERIOD = 32'h0000_0004;
    localparam logic [31:0] OFF_CMP    = 32'h0000_0008;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0100;
    localparam logic [31:0] OFF_IM     = 32'h0000_0208;
    localparam logic [31:0] OFF_ICR    = 32'h0000_020C;
    localparam logic [31:0] RUN_WORD   = {15'b0, 1'b1, 4'b0, CLK_SRC, 5'b0, 3'b111};
    localparam logic [7:0]  ACK_LAST   = 8'(ACK_TO - 1);
    localparam logic [AW:0] DEPTH_L    = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L      = (AW+1)'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_PERIOD, S_W_CMP, S_W_IM, S_W_CTRL,
        S_HOLD, S_WAIT, S_W_ICR, S_W_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] index_q, index_d;
    logic [AW:0]   len_q, len_d;
    logic          loop_q, loop_d;
    logic [31:0]   period_q, period_d;
    logic          first_q, first_d;
    logic          stop_q, stop_d;
    logic          gap_q, gap_d;
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;

    logic [31:0]   tbl_q [DEPTH];
    logic          is_wr;
    logic          wr_done;
    logic [AW:0]   next_idx;
    logic          unused_dat;

    assign unused_dat = ^m_dat_i;

    always_ff @(posedge clk_i) begin
        if (tbl_we_i) begin
            tbl_q[tbl_addr_i] <= tbl_wdata_i;
        end
    end

    assign is_wr = (state_q == S_W_PERIOD) || (state_q == S_W_CMP) ||
                   (state_q == S_W_IM)     || (state_q == S_W_CTRL) ||
                   (state_q == S_W_ICR)    || (state_q == S_W_STOP);

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        len_d    = len_q;
        loop_d   = loop_q;
        period_d = period_q;
        first_d  = first_q;
        stop_d   = stop_q | (stop_i & (state_q != S_IDLE));
        gap_d    = gap_q;
        to_cnt_d = '0;
        hold_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_done  = 1'b0;
        next_idx = {1'b0, index_q} + ONE_L;

        // gap_q marks the idle cycle after ack; the state advances only then
        if (is_wr) begin
            if (gap_q) begin
                gap_d   = 1'b0;
                wr_done = 1'b1;
            end else if (m_ack_i) begin
                gap_d = 1'b1;
            end else if (to_cnt_q == ACK_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if ((seq_len_i == '0) || (seq_len_i > DEPTH_L)) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = seq_len_i;
                        loop_d   = loop_i;
                        period_d = period_i;
                        index_d  = '0;
                        first_d  = 1'b1;
                        state_d  = S_W_PERIOD;
                    end
                end
            end
            S_W_PERIOD: if (wr_done) state_d = S_W_CMP;
            S_W_CMP:    if (wr_done) state_d = first_q ? S_W_IM : S_HOLD;
            S_W_IM:     if (wr_done) state_d = S_W_CTRL;
            S_W_CTRL: begin
                if (wr_done) begin
                    first_d = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q) state_d = S_WAIT;
                else        hold_d  = 1'b1;
            end
            S_WAIT: begin
                if (stop_q)         state_d = S_W_STOP;
                else if (tmr_irq_i) state_d = S_W_ICR;
            end
            S_W_ICR: begin
                if (wr_done) begin
                    if (next_idx < len_q) begin
                        index_d = next_idx[AW-1:0];
                        state_d = S_W_CMP;
                    end else if (loop_q) begin
                        index_d = '0;
                        state_d = S_W_CMP;
                    end else begin
                        state_d = S_W_STOP;
                    end
                end
            end
            S_W_STOP: begin
                if (wr_done) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) stop_d = 1'b0;
    end

    // Address/data are captured on entry so they stay stable for the whole cycle
    always_comb begin
        adr_d = adr_q;
        dat_d = dat_q;
        if (state_d != state_q) begin
            case (state_d)
                S_W_PERIOD: begin adr_d = TMR_BASE + OFF_PERIOD; dat_d = period_d;        end
                S_W_CMP:    begin adr_d = TMR_BASE + OFF_CMP;    dat_d = tbl_q[index_d];  end
                S_W_IM:     begin adr_d = TMR_BASE + OFF_IM;     dat_d = 32'h1;           end
                S_W_CTRL:   begin adr_d = TMR_BASE + OFF_CTRL;   dat_d = RUN_WORD;        end
                S_W_ICR:    begin adr_d = TMR_BASE + OFF_ICR;    dat_d = 32'h1;           end
                S_W_STOP:   begin adr_d = TMR_BASE + OFF_CTRL;   dat_d = 32'h0;           end
                default:    begin adr_d = adr_q;                 dat_d = dat_q;           end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            period_q <= '0;
            first_q  <= 1'b0;
            stop_q   <= 1'b0;
            gap_q    <= 1'b0;
            to_cnt_q <= '0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            period_q <= period_d;
            first_q  <= first_d;
            stop_q   <= stop_d;
            gap_q    <= gap_d;
            to_cnt_q <= to_cnt_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
        end
    end

    assign m_cyc_o = is_wr & ~gap_q;
    assign m_stb_o = m_cyc_o;
    assign m_we_o  = m_cyc_o;
    assign m_sel_o = {4{m_cyc_o}};
    assign m_adr_o = m_cyc_o ? adr_q : '0;
    assign m_dat_o = m_cyc_o ? dat_q : '0;
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign step_o  = index_q;

endmodule
